hash160_seq: RTL and testbench

- Controller that sequences the Hash160 datapath: captures a framed 64-byte message from the byte stream and runs two SHA-256 compressions followed by one RIPEMD-160 compression.
- Builds all padding blocks internally.
- Sits between the top-level byte input (i_text) and the SHA-256 and RIPEMD-160 cores; drives o_answer/o_valid at the top level.

---
 rtl/hash160_seq.sv | 147 ++++++++++++++
 tb/tb_hash160_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hash160_seq.sv
// hash160_seq - sequencer for the Hash160 datapath (RIPEMD160(SHA256(msg))).
//
// Frames a 64-byte message from the byte stream (opened by START_BYTE while
// idle). It then runs three compressions:
//   1. SHA-256 on the message block, starting from the IV.
//   2. SHA-256 on an internally built padding block, chained from step 1.
//   3. RIPEMD-160 on the 32-byte SHA digest plus its padding.
//
// Parameters:
//   START_BYTE   framing byte recognised only in IDLE
//   TIMEOUT_CYC  watchdog limit per core operation (used only with the
//                optional watchdog)
//
// Optional feature: define HASH160_SEQ_TIMEOUT_EN to add a 10-bit per-operation
// watchdog and the o_error output. Without it the controller waits
// indefinitely for each done pulse.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   i_text                byte stream input
//   sha_block/first/start block, IV-select and start pulse to the SHA-256 core
//   sha_done/sha_digest   SHA-256 completion pulse and digest
//   rmd_block/rmd_start   block and start pulse to the RIPEMD-160 core
//   rmd_done/rmd_digest   RIPEMD-160 completion pulse and digest
//   o_answer/o_valid      Hash160 result and its one-cycle update strobe
//   o_error               watchdog expiry pulse (optional)
//   o_busy                high whenever not IDLE
module hash160_seq #(
    parameter logic [7:0]  START_BYTE  = 8'hAA,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   i_text,
    output logic [511:0] sha_block,
    output logic         sha_first,
    output logic         sha_start,
    input  logic         sha_done,
    input  logic [255:0] sha_digest,
    output logic [511:0] rmd_block,
    output logic         rmd_start,
    input  logic         rmd_done,
    input  logic [159:0] rmd_digest,
    output logic [159:0] o_answer,
    output logic         o_valid,
`ifdef HASH160_SEQ_TIMEOUT_EN
    output logic         o_error,
`endif
    output logic         o_busy
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHA1, S_SHA2, S_RMD} state_t;

    localparam logic [511:0] SHA_PAD = {8'h80, 488'd0, 8'h02, 8'h00};
    localparam logic [255:0] RMD_PAD = {8'h80, 184'd0, 8'h00, 8'h01, 48'd0};

    state_t         state_q, state_d;
    logic [5:0]     cnt_q;
    logic [511:0]   msg_q;
    logic [255:0]   dig_q;
    logic [159:0]   hold_q, ans_q;
    logic           first_q, fin_q, valid_q;
    logic           in_sha, sha_take, rmd_take, enter_core, timeout_hit;

`ifdef HASH160_SEQ_TIMEOUT_EN
    logic [9:0]     wdog_q;
    logic           err_q;
`endif

    always_comb begin
        state_d     = state_q;
        in_sha      = (state_q == S_SHA1) || (state_q == S_SHA2);
        sha_take    = in_sha && sha_done && !first_q;
        rmd_take    = (state_q == S_RMD) && rmd_done && !first_q;
        timeout_hit = 1'b0;
`ifdef HASH160_SEQ_TIMEOUT_EN
        timeout_hit = (in_sha || state_q == S_RMD) && !sha_take && !rmd_take &&
                      (wdog_q == 10'(TIMEOUT_CYC - 1));
`endif
        case (state_q)
            S_IDLE:  if (i_text == START_BYTE) state_d = S_LOAD;
            S_LOAD:  if (cnt_q == 6'd63)       state_d = S_SHA1;
            S_SHA1:  if (sha_take)             state_d = S_SHA2;
            S_SHA2:  if (sha_take)             state_d = S_RMD;
            S_RMD:   if (rmd_take)             state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
        if (timeout_hit) state_d = S_IDLE;
        enter_core = (state_d != state_q) &&
                     (state_d == S_SHA1 || state_d == S_SHA2 || state_d == S_RMD);
    end

    always_comb begin
        sha_block = 512'd0;
        if (state_q == S_SHA1)      sha_block = msg_q;
        else if (state_q == S_SHA2) sha_block = SHA_PAD;
        rmd_block = (state_q == S_RMD) ? {dig_q, RMD_PAD} : 512'd0;
        sha_first = (state_q == S_SHA1);
        sha_start = first_q && in_sha;
        rmd_start = first_q && (state_q == S_RMD);
        o_busy    = (state_q != S_IDLE);
        o_answer  = ans_q;
        o_valid   = valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            msg_q   <= 512'd0;
            dig_q   <= 256'd0;
            hold_q  <= 160'd0;
            ans_q   <= 160'd0;
            first_q <= 1'b0;
            fin_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= enter_core;
            if (state_q == S_LOAD) begin
                msg_q[{~cnt_q, 3'b000} +: 8] <= i_text;
                cnt_q <= cnt_q + 6'd1;
            end else begin
                cnt_q <= 6'd0;
            end
            if (state_q == S_SHA2 && sha_take) dig_q <= sha_digest;
            if (rmd_take) hold_q <= rmd_digest;
            fin_q   <= rmd_take;
            valid_q <= fin_q;
            if (fin_q) ans_q <= hold_q;
        end
    end

`ifdef HASH160_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= 10'd0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= enter_core ? 10'd0 : wdog_q + 10'd1;
            err_q  <= timeout_hit;
        end
    end
    assign o_error = err_q;
`endif

endmodule

// File: tb/tb_hash160_seq.sv
module tb_hash160_seq;

    localparam logic [255:0] SHA_STUB = {2{128'h00112233445566778899AABBCCDDEEFF}};
    localparam logic [159:0] RMD_A = 160'hDEADBEEF0123456789ABCDEFFEDCBA9876543210;
    localparam logic [159:0] RMD_B = 160'h0F1E2D3C4B5A69788796A5B4C3D2E1F011223344;
    localparam logic [159:0] RMD_C = 160'hCAFEF00D00000000111111112222222233333333;
    localparam logic [159:0] RMD_D = 160'h123456789ABCDEF0123456789ABCDEF012345678;
    localparam logic [511:0] EXP_PAD =
        512'h80000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000200;
    localparam logic [255:0] EXP_RTAIL =
        256'h80000000_00000000_00000000_00000000_00000000_00000000_00010000_00000000;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   i_text;
    logic [511:0] sha_block, rmd_block;
    logic         sha_first, sha_start, rmd_start, o_valid, o_busy;
    logic         sha_done = 1'b0, rmd_done = 1'b0;
    logic [255:0] sha_digest;
    logic [159:0] rmd_digest, o_answer, rmd_val;
`ifdef HASH160_SEQ_TIMEOUT_EN
    logic         o_error;
`endif

    int vec = 0, errs = 0;
    int sha_lat = 1, sha_cnt = 0, n;
    logic rmd_en = 1'b1;
    logic [511:0] sha_blk_log[$];
    logic         sha_first_log[$];
    logic [511:0] rmd_blk_log[$];
    logic [511:0] m2, m3, m4;

    always #5 clk = ~clk;

    assign sha_digest = SHA_STUB;
    assign rmd_digest = rmd_val;

    hash160_seq #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .i_text(i_text),
        .sha_block(sha_block), .sha_first(sha_first), .sha_start(sha_start),
        .sha_done(sha_done), .sha_digest(sha_digest),
        .rmd_block(rmd_block), .rmd_start(rmd_start),
        .rmd_done(rmd_done), .rmd_digest(rmd_digest),
        .o_answer(o_answer), .o_valid(o_valid),
`ifdef HASH160_SEQ_TIMEOUT_EN
        .o_error(o_error),
`endif
        .o_busy(o_busy)
    );

    always @(posedge clk) begin
        sha_done <= 1'b0;
        if (sha_start) begin
            sha_blk_log.push_back(sha_block);
            sha_first_log.push_back(sha_first);
            if (sha_lat == 1) sha_done <= 1'b1;
            else sha_cnt <= sha_lat - 1;
        end else if (sha_cnt != 0) begin
            sha_cnt <= sha_cnt - 1;
            if (sha_cnt == 1) sha_done <= 1'b1;
        end
    end

    always @(posedge clk) begin
        rmd_done <= rmd_start && rmd_en;
        if (rmd_start) rmd_blk_log.push_back(rmd_block);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [511:0] msg, input bit hdr);
        if (hdr) begin
            i_text = 8'hAA;
            tick();
        end
        for (int k = 0; k < 64; k++) begin
            i_text = msg[(63 - k) * 8 +: 8];
            tick();
        end
        i_text = 8'h00;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!o_valid && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    task automatic clear_logs();
        sha_blk_log.delete();
        sha_first_log.delete();
        rmd_blk_log.delete();
    endtask

    initial begin
        for (int k = 0; k < 64; k++) begin
            m2[(63 - k) * 8 +: 8] = 8'(k);
            m3[(63 - k) * 8 +: 8] = 8'(255 - k);
            m4[(63 - k) * 8 +: 8] = 8'(k * 3);
        end
        m2[(63 - 10) * 8 +: 8] = 8'hAA;

        rst = 1'b1; i_text = 8'h00; rmd_val = RMD_A;
        tick(); tick();
        check("rst_busy",   512'(o_busy),    512'(0));
        check("rst_valid",  512'(o_valid),   512'(0));
        check("rst_answer", 512'(o_answer),  512'(0));
        check("rst_sstart", 512'(sha_start), 512'(0));
        check("rst_sblock", sha_block,       512'(0));
        check("rst_rblock", rmd_block,       512'(0));
        rst = 1'b0; i_text = 8'h55;
        tick();
        check("idle_ignore", 512'(o_busy), 512'(0));

        clear_logs();
        send_frame(512'd0, 1'b1);
        wait_valid(n);
        check("f1_latency", 512'(n), 512'(7));
        check("f1_answer",  512'(o_answer), 512'(RMD_A));
        check("f1_busy",    512'(o_busy), 512'(0));
        tick();
        check("f1_pulse",   512'(o_valid), 512'(0));
        check("f1_hold",    512'(o_answer), 512'(RMD_A));
        check("f1_nsha",    512'(sha_blk_log.size()), 512'(2));
        check("f1_nrmd",    512'(rmd_blk_log.size()), 512'(1));
        if (sha_blk_log.size() == 2 && rmd_blk_log.size() == 1) begin
            check("f1_blk0",   sha_blk_log[0], 512'd0);
            check("f1_first0", 512'(sha_first_log[0]), 512'(1));
            check("f1_blk1",   sha_blk_log[1], EXP_PAD);
            check("f1_first1", 512'(sha_first_log[1]), 512'(0));
            check("f1_rblk",   rmd_blk_log[0], {SHA_STUB, EXP_RTAIL});
        end

        i_text = 8'h55; tick();
        i_text = 8'h13; tick();
        check("f2_junk", 512'(o_busy), 512'(0));
        sha_lat = 6; rmd_val = RMD_B;
        clear_logs();
        send_frame(m2, 1'b1);
        i_text = 8'hAA;
        n = 0;
        while (!o_valid && n < 200) begin
            tick();
            n++;
            if (!o_busy) i_text = 8'h00;
        end
        check("f2_latency", 512'(n), 512'(17));
        check("f2_busy",    512'(o_busy), 512'(0));
        check("f2_answer",  512'(o_answer), 512'(RMD_B));
        check("f2_nsha",    512'(sha_blk_log.size()), 512'(2));
        if (sha_blk_log.size() != 0) check("f2_blk0", sha_blk_log[0], m2);

        i_text = 8'hAA;
        tick();
        check("f3_accept", 512'(o_busy), 512'(1));
        sha_lat = 1; rmd_val = RMD_C;
        clear_logs();
        send_frame(m3, 1'b0);
        check("f3_oldans", 512'(o_answer), 512'(RMD_B));
        wait_valid(n);
        check("f3_latency", 512'(n), 512'(7));
        check("f3_answer",  512'(o_answer), 512'(RMD_C));
        if (sha_blk_log.size() != 0) check("f3_blk0", sha_blk_log[0], m3);

        clear_logs();
        i_text = 8'hAA; tick();
        for (int k = 0; k < 30; k++) begin
            i_text = m4[(63 - k) * 8 +: 8];
            tick();
        end
        rst = 1'b1; i_text = m4[(63 - 30) * 8 +: 8];
        tick();
        check("mr_busy",   512'(o_busy),   512'(0));
        check("mr_answer", 512'(o_answer), 512'(0));
        rst = 1'b0; i_text = 8'h00;
        tick(); tick();
        check("mr_nostart", 512'(sha_blk_log.size()), 512'(0));
        rmd_val = RMD_D;
        send_frame(m4, 1'b1);
        wait_valid(n);
        check("mr_latency", 512'(n), 512'(7));
        check("mr_answer2", 512'(o_answer), 512'(RMD_D));
        if (sha_blk_log.size() != 0) check("mr_blk0", sha_blk_log[0], m4);

`ifdef HASH160_SEQ_TIMEOUT_EN
        rmd_en = 1'b0;
        send_frame(m4, 1'b1);
        n = 0;
        while (!rmd_start && n < 200) begin tick(); n++; end
        n = 0;
        begin
            logic seen_valid;
            seen_valid = 1'b0;
            while (!o_error && n < 200) begin
                tick();
                n++;
                if (o_valid) seen_valid = 1'b1;
            end
            check("to_delay", 512'(n), 512'(16));
            check("to_valid", 512'(seen_valid), 512'(0));
        end
        check("to_busy",   512'(o_busy), 512'(0));
        check("to_answer", 512'(o_answer), 512'(RMD_D));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
